// File: rtl/tpu_pkg.sv
// Shared types and constants for the systolic-array host path.
package tpu_pkg;

    typedef enum logic {
        LOAD    = 1'b0,
        COMPUTE = 1'b1
    } state_e;

    localparam int BYTES_PER_LOAD = 8;
    localparam int MMU_CYCLE_W    = 3;
    localparam int IDX_W          = $clog2(BYTES_PER_LOAD);

    typedef logic [BYTES_PER_LOAD-1:0][7:0] bank_t;

    // Returns the bank with one byte replaced, so a byte accepted on a commit
    // edge can be folded into the committed image.
    function automatic bank_t merge_byte(input bank_t bank, input logic [IDX_W-1:0] idx,
                                         input logic [7:0] data, input logic we);
        bank_t r;
        r = bank;
        if (we) r[idx] = data;
        return r;
    endfunction

endpackage

// File: rtl/loader_bank.sv
// 8-byte register bank: single-byte write port, whole-bank parallel load, synchronous clear.
module loader_bank
    import tpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  widx_i,
    input  logic [7:0]        wdata_i,
    input  logic              ld_i,
    input  bank_t             ld_data_i,
    output bank_t             bank_o
);

    bank_t bank_q;

    // NOTE: this small register file is reset because the feeder must see zeros
    // after reset; large memories would normally be left unreset.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            bank_q <= '0;
        end else if (ld_i) begin
            bank_q <= ld_data_i;
        end else if (we_i) begin
            bank_q[widx_i] <= wdata_i;
        end
    end

    assign bank_o = bank_q;

endmodule

// File: rtl/host_loader.sv
// Host byte-stream loader for the 2x2 systolic array feeder.
// Optional HOST_LOADER_PRELOAD_EN adds a staging bank for back-to-back operations.
module host_loader
    import tpu_pkg::*;
#(
    parameter int MMU_CYCLES = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic [7:0]             weight0,
    output logic [7:0]             weight1,
    output logic [7:0]             weight2,
    output logic [7:0]             weight3,
    output logic [7:0]             input0,
    output logic [7:0]             input1,
    output logic [7:0]             input2,
    output logic [7:0]             input3,
    output logic                   en,
    output logic [MMU_CYCLE_W-1:0] mmu_cycle,
    output logic                   busy
);

    localparam logic [MMU_CYCLE_W-1:0] LAST_CYCLE = MMU_CYCLE_W'(MMU_CYCLES - 1);
    localparam logic [IDX_W-1:0]       LAST_BYTE  = IDX_W'(BYTES_PER_LOAD - 1);

    state_e                 state_q;
    logic [MMU_CYCLE_W-1:0] cycle_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   en_q;
    logic                   busy_q;
    bank_t                  active;

    logic accept;
    logic accept_last;
    logic cycle_end;
    logic commit;

    assign accept      = in_valid && in_ready;
    assign accept_last = accept && (idx_q == LAST_BYTE);
    assign cycle_end   = (state_q == COMPUTE) && (cycle_q == LAST_CYCLE);

`ifdef HOST_LOADER_PRELOAD_EN
    logic  stage_full_q;
    bank_t stage;

    assign in_ready = !stage_full_q;
    // Commit when a full image exists (or completes now) and the array is free.
    assign commit   = (stage_full_q || accept_last) && ((state_q == LOAD) || cycle_end);

    loader_bank u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (1'b0),
        .we_i      (accept),
        .widx_i    (idx_q),
        .wdata_i   (in_data),
        .ld_i      (1'b0),
        .ld_data_i ('0),
        .bank_o    (stage)
    );

    loader_bank u_active (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (1'b0),
        .we_i      (1'b0),
        .widx_i    ('0),
        .wdata_i   ('0),
        .ld_i      (commit),
        .ld_data_i (merge_byte(stage, idx_q, in_data, accept)),
        .bank_o    (active)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_full_q <= 1'b0;
        end else if (commit) begin
            stage_full_q <= 1'b0;
        end else if (accept_last) begin
            stage_full_q <= 1'b1;
        end
    end
`else
    assign in_ready = (state_q == LOAD);
    assign commit   = accept_last;

    loader_bank u_active (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (1'b0),
        .we_i      (accept),
        .widx_i    (idx_q),
        .wdata_i   (in_data),
        .ld_i      (1'b0),
        .ld_data_i ('0),
        .bank_o    (active)
    );
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD;
            cycle_q <= '0;
            idx_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            if (accept) idx_q <= idx_q + IDX_W'(1);
            if (commit) begin
                state_q <= COMPUTE;
                cycle_q <= '0;
                en_q    <= 1'b1;
                busy_q  <= 1'b1;
            end else if (cycle_end) begin
                state_q <= LOAD;
                cycle_q <= '0;
                en_q    <= 1'b0;
                busy_q  <= 1'b0;
            end else if (state_q == COMPUTE) begin
                cycle_q <= cycle_q + MMU_CYCLE_W'(1);
            end
        end
    end

    assign en        = en_q;
    assign busy      = busy_q;
    assign mmu_cycle = cycle_q;
    assign weight0   = active[0];
    assign weight1   = active[1];
    assign weight2   = active[2];
    assign weight3   = active[3];
    assign input0    = active[4];
    assign input1    = active[5];
    assign input2    = active[6];
    assign input3    = active[7];

endmodule

// File: tb/tb_host_loader.sv
// Directed self-checking bench for host_loader (default build or HOST_LOADER_PRELOAD_EN).
module tb_host_loader;

`ifdef HOST_LOADER_PRELOAD_EN
    localparam int MC = 8;
`else
    localparam int MC = 6;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [7:0] weight0, weight1, weight2, weight3;
    logic [7:0] input0, input1, input2, input3;
    logic       en;
    logic [2:0] mmu_cycle;
    logic       busy;

    host_loader #(.MMU_CYCLES(MC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .weight0   (weight0),
        .weight1   (weight1),
        .weight2   (weight2),
        .weight3   (weight3),
        .input0    (input0),
        .input1    (input1),
        .input2    (input2),
        .input3    (input3),
        .en        (en),
        .mmu_cycle (mmu_cycle),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] out_byte(input int k);
        case (k)
            0: return weight0;
            1: return weight1;
            2: return weight2;
            3: return weight3;
            4: return input0;
            5: return input1;
            6: return input2;
            default: return input3;
        endcase
    endfunction

    task automatic check_regs(input string tag, input logic [63:0] exp);
        for (int k = 0; k < 8; k++)
            check($sformatf("%s[%0d]", tag, k), {24'h0, out_byte(k)}, {24'h0, exp[k*8 +: 8]});
    endtask

    task automatic load_set(input logic [63:0] s);
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_data = s[k*8 +: 8];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (en && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_en_low"}, {31'h0, en}, 32'h0);
        check({tag, "_ready"}, {31'h0, in_ready}, 32'h1);
    endtask

    localparam logic [63:0] SET_A = 64'h0807060504030201;
    localparam logic [63:0] SET_B = 64'h8877665544332211;
    localparam logic [63:0] SET_D = 64'hD8D7D6D5D4D3D2D1;

    initial begin
        // Reset with in_valid asserted: bytes must be ignored.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        tick();
        check("rst_en", {31'h0, en}, 32'h0);
        check("rst_cycle", {29'h0, mmu_cycle}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check_regs("rst_regs", 64'h0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        check("rst_ready", {31'h0, in_ready}, 32'h1);

`ifndef HOST_LOADER_PRELOAD_EN
        // Back-to-back stream 01..08.
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'(i + 1);
            tick();
            if (i < 7) begin
                check($sformatf("strm_byte%0d", i), {24'h0, out_byte(i)}, i + 1);
                check($sformatf("strm_en%0d", i), {31'h0, en}, 32'h0);
            end
        end
        check("strm_en_rise", {31'h0, en}, 32'h1);
        check("strm_cycle0", {29'h0, mmu_cycle}, 32'h0);
        check("strm_busy", {31'h0, busy}, 32'h1);
        check("strm_ready", {31'h0, in_ready}, 32'h0);
        check_regs("strm_regs", SET_A);

        // in_valid stays high with changing data through COMPUTE.
        for (int c = 0; c < MC; c++) begin
            check($sformatf("cmp_cycle%0d", c), {29'h0, mmu_cycle}, c);
            check($sformatf("cmp_en%0d", c), {31'h0, en}, 32'h1);
            check($sformatf("cmp_ready%0d", c), {31'h0, in_ready}, 32'h0);
            in_data = 8'hA0 + 8'(c);
            tick();
        end
        in_valid = 1'b0;
        check("end_en", {31'h0, en}, 32'h0);
        check("end_cycle", {29'h0, mmu_cycle}, 32'h0);
        check("end_ready", {31'h0, in_ready}, 32'h1);
        check("end_busy", {31'h0, busy}, 32'h0);
        check_regs("hold_regs", SET_A);

        // Gapped in_valid: counter advances only on handshakes, restarts at byte 0.
        for (int i = 0; i < 16; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = (i % 2 == 0) ? SET_B[(i/2)*8 +: 8] : 8'hEE;
            tick();
            if (i == 14)
                check("gap_en_rise", {31'h0, en}, 32'h1);
            else if (i % 2 == 0)
                check($sformatf("gap_byte%0d", i/2), {24'h0, out_byte(i/2)}, {24'h0, SET_B[(i/2)*8 +: 8]});
        end
        in_valid = 1'b0;
        check("gap_cycle1", {29'h0, mmu_cycle}, 32'h1);
        check_regs("gap_regs", SET_B);
        drain("gap");

        // Reset in the middle of COMPUTE.
        load_set(SET_A);
        tick();
        tick();
        tick();
        check("mid_cycle3", {29'h0, mmu_cycle}, 32'h3);
        rst_n = 1'b0;
        tick();
        check("mid_rst_en", {31'h0, en}, 32'h0);
        check("mid_rst_cycle", {29'h0, mmu_cycle}, 32'h0);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check_regs("mid_rst_regs", 64'h0);
        rst_n = 1'b1;

        // Partial 3-byte load then reset: next load restarts at byte 0.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'hC1 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        check("part_w2", {24'h0, weight2}, 32'hC3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("part_rst_w0", {24'h0, weight0}, 32'h0);
        load_set(SET_D);
        check("part_en", {31'h0, en}, 32'h1);
        check_regs("part_regs", SET_D);
        drain("part");
`else
        // Load A, then stream B during A's window so B's last byte lands on the final cycle.
        load_set(SET_A);
        check("pre_en_rise", {31'h0, en}, 32'h1);
        check_regs("pre_a", SET_A);
        in_valid = 1'b1;
        for (int c = 0; c < MC; c++) begin
            check($sformatf("pre_cycle%0d", c), {29'h0, mmu_cycle}, c);
            check($sformatf("pre_en%0d", c), {31'h0, en}, 32'h1);
            check($sformatf("pre_ready%0d", c), {31'h0, in_ready}, 32'h1);
            check($sformatf("pre_w0_%0d", c), {24'h0, weight0}, 32'h01);
            check($sformatf("pre_i3_%0d", c), {24'h0, input3}, 32'h08);
            in_data = SET_B[c*8 +: 8];
            tick();
        end
        in_valid = 1'b0;
        check("b2b_en", {31'h0, en}, 32'h1);
        check("b2b_cycle", {29'h0, mmu_cycle}, 32'h0);
        check("b2b_ready", {31'h0, in_ready}, 32'h1);
        check_regs("b2b_regs", SET_B);
        drain("b2b");
        check("b2b_cycle_end", {29'h0, mmu_cycle}, 32'h0);
        check_regs("b2b_hold", SET_B);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
